jadwal_penyiraman: RTL

JADWAL_PENYIRAMAN -- requirements
Module: jadwal_penyiraman

---
 rtl/jadwal_penyiraman.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/jadwal_penyiraman.sv
// jadwal_penyiraman -- irrigation scheduler.
// Averages four soil-moisture samples and, when the soil is dry, requests a
// watering duration from the irrigation controller. The request is held until
// the controller acknowledges by raising watering_in_progress. A missing
// acknowledge latches a sticky fault. Every watering is followed by a fixed
// cooldown.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   moisture[7:0]        unsigned moisture sample
//   moisture_valid       moisture is valid this cycle
//   sensor_enable        controller permits sensing
//   watering_in_progress controller is watering (acknowledge)
//   manual_req           one-cycle pulse forcing a MAX_TIME watering
//   irrigation_time[7:0] requested duration, 0 = no request
//   busy                 high in every state except IDLE
//   fault                sticky acknowledge-timeout flag
//   water_count[7:0]     completed waterings, wraps at 256
module jadwal_penyiraman #(
    parameter int DRY_THRESH  = 80,
    parameter int WET_TARGET  = 120,
    parameter int MIN_TIME    = 4,
    parameter int MAX_TIME    = 60,
    parameter int ACK_TIMEOUT = 8,
    parameter int COOLDOWN    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] moisture,
    input  logic       moisture_valid,
    input  logic       sensor_enable,
    input  logic       watering_in_progress,
    input  logic       manual_req,
    output logic [7:0] irrigation_time,
    output logic       busy,
    output logic       fault,
    output logic [7:0] water_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_REQUEST,
        ST_WATERING,
        ST_COOLDOWN,
        ST_FAULT
    } state_t;

    localparam logic [7:0] DRY_T     = 8'(DRY_THRESH);
    localparam logic [7:0] WET_T     = 8'(WET_TARGET);
    localparam logic [7:0] MIN_T     = 8'(MIN_TIME);
    localparam logic [7:0] MAX_T     = 8'(MAX_TIME);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);

    state_t     state, state_next;
    logic [9:0] sum, sum_next;
    logic [1:0] sample_cnt, sample_cnt_next;
    logic [7:0] ack_timer, ack_timer_next;
    logic [7:0] cool_cnt, cool_cnt_next;
    logic [7:0] irrigation_time_next;
    logic       busy_next;
    logic       fault_next;
    logic [7:0] water_count_next;

    // Running sum including the current sample; four 8-bit samples fit in 10 bits.
    logic [9:0] sum_acc;
    logic [7:0] avg;
    logic [7:0] diff;
    logic [7:0] clamped;

    assign sum_acc = sum + {2'b00, moisture};
    assign avg     = sum_acc[9:2];
    // avg < DRY_THRESH <= WET_TARGET whenever this is used, so no underflow.
    assign diff    = WET_T - avg;

    always_comb begin
        if (diff < MIN_T)
            clamped = MIN_T;
        else if (diff > MAX_T)
            clamped = MAX_T;
        else
            clamped = diff;
    end

    // State register plus every registered output, counter and the sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            sum             <= '0;
            sample_cnt      <= '0;
            ack_timer       <= '0;
            cool_cnt        <= '0;
            irrigation_time <= '0;
            busy            <= 1'b0;
            fault           <= 1'b0;
            water_count     <= '0;
        end else begin
            state           <= state_next;
            sum             <= sum_next;
            sample_cnt      <= sample_cnt_next;
            ack_timer       <= ack_timer_next;
            cool_cnt        <= cool_cnt_next;
            irrigation_time <= irrigation_time_next;
            busy            <= busy_next;
            fault           <= fault_next;
            water_count     <= water_count_next;
        end
    end

    // Next-state logic. Manual requests only matter before a request exists;
    // in REQUEST an acknowledge takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (manual_req)
                    state_next = ST_REQUEST;
                else if (sensor_enable && moisture_valid)
                    state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (manual_req)
                    state_next = ST_REQUEST;
                else if (!sensor_enable)
                    state_next = ST_IDLE;
                else if (moisture_valid && sample_cnt == 2'd3)
                    state_next = (avg < DRY_T) ? ST_REQUEST : ST_IDLE;
            end
            ST_REQUEST: begin
                if (watering_in_progress)
                    state_next = ST_WATERING;
                else if (ack_timer == ACK_LAST)
                    state_next = ST_FAULT;
            end
            ST_WATERING: begin
                if (!watering_in_progress)
                    state_next = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (cool_cnt == COOL_LAST)
                    state_next = ST_IDLE;
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values for outputs, counters and the sum. Counters and the sum are
    // cleared on any state change; the IDLE->SAMPLE entry then loads the
    // triggering sample as the first one.
    always_comb begin
        sum_next             = sum;
        sample_cnt_next      = sample_cnt;
        ack_timer_next       = ack_timer;
        cool_cnt_next        = cool_cnt;
        irrigation_time_next = irrigation_time;
        fault_next           = fault;
        water_count_next     = water_count;
        busy_next            = (state_next != ST_IDLE);

        if (state_next != state) begin
            sum_next        = '0;
            sample_cnt_next = '0;
            ack_timer_next  = '0;
            cool_cnt_next   = '0;
        end

        case (state)
            ST_IDLE: begin
                if (state_next == ST_SAMPLE) begin
                    sum_next        = {2'b00, moisture};
                    sample_cnt_next = 2'd1;
                end else if (state_next == ST_REQUEST) begin
                    irrigation_time_next = MAX_T;
                end
            end
            ST_SAMPLE: begin
                if (state_next == ST_SAMPLE && moisture_valid) begin
                    sum_next        = sum_acc;
                    sample_cnt_next = sample_cnt + 2'd1;
                end else if (state_next == ST_REQUEST) begin
                    irrigation_time_next = manual_req ? MAX_T : clamped;
                end
            end
            ST_REQUEST: begin
                if (state_next == ST_REQUEST) begin
                    ack_timer_next = ack_timer + 8'd1;
                end else begin
                    irrigation_time_next = '0;
                    if (state_next == ST_FAULT)
                        fault_next = 1'b1;
                end
            end
            ST_WATERING: begin
                if (state_next == ST_COOLDOWN)
                    water_count_next = water_count + 8'd1;
            end
            ST_COOLDOWN: begin
                if (state_next == ST_COOLDOWN)
                    cool_cnt_next = cool_cnt + 8'd1;
            end
            ST_FAULT: irrigation_time_next = '0;
            default: ;
        endcase
    end

endmodule
